hazard_scoreboard: RTL and testbench

- Next-generation load-use hazard unit for the 5-stage RV32 pipeline, supporting multi-cycle, in-order data memory.
- Tracks up to DEPTH outstanding loads in a destination-register scoreboard FIFO.
- Stalls ID on any RAW dependency against the load in EX or against any in-flight load.
- Stalls EX when the outstanding-load FIFO is full. Sits between the ID/EX register and the MEM interface.

---
 rtl/hazard_scoreboard_pkg.sv | 19 +
 rtl/hazard_scoreboard_pending_rd_fifo.sv | 67 ++++++
 rtl/hazard_scoreboard.sv | 139 +++++++++++++
 tb/tb_hazard_scoreboard.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// hazard_scoreboard_pkg: shared defaults and helpers for the load-use hazard unit.
// Optional statistics counters are enabled with the HAZARD_STATS_EN macro.
package hazard_scoreboard_pkg;

    // Default register address width for RV32.
    localparam int REG_AW_DEF      = 5;
    // Default number of outstanding loads tracked.
    localparam int HAZ_DEPTH_DEF   = 4;
    // Head entry is always compared against ID sources.
    localparam int RESP_BYPASS_OFF = 0;
    // Head entry is skipped in its response cycle; MEM/WB forwarding covers it.
    localparam int RESP_BYPASS_ON  = 1;

    // Width of a counter that must hold values 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_pending_rd_fifo.sv
// pending_rd_fifo: in-order FIFO of destination registers for loads that have
// left EX but not yet returned. Exposes every slot plus a per-slot valid mask
// so the parent can compare all in-flight destinations in parallel.
module pending_rd_fifo
    import hazard_scoreboard_pkg::*;
#(
    parameter int AW    = REG_AW_DEF,
    parameter int DEPTH = HAZ_DEPTH_DEF
)
(
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_push,
    input  logic [AW-1:0]                 i_push_rd,
    input  logic                          i_pop,
    output logic [DEPTH-1:0][AW-1:0]      o_entries,
    output logic [DEPTH-1:0]              o_valid,
    output logic [$clog2(DEPTH)-1:0]      o_head,
    output logic [$clog2(DEPTH):0]        o_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = cnt_width(DEPTH);

    logic [PW-1:0]              r_wr_ptr;
    logic [PW-1:0]              r_rd_ptr;
    logic [CW-1:0]              r_count;
    logic [DEPTH-1:0][AW-1:0]   r_mem;
    logic [DEPTH-1:0]           r_valid;

    // Pointers wrap naturally because DEPTH is a power of two; the separate
    // count keeps full and empty distinguishable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            if (i_push && !i_pop)      r_count <= r_count + CW'(1);
            else if (i_pop && !i_push) r_count <= r_count - CW'(1);
        end
    end

    // Per-slot valid bits; a push into the slot being popped (full, push+pop)
    // wins so the slot stays live.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
        end else begin
            if (i_pop)  r_valid[r_rd_ptr] <= 1'b0;
            if (i_push) r_valid[r_wr_ptr] <= 1'b1;
        end
    end

    // Destination storage; contents are qualified by r_valid so no reset needed.
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_push_rd;
    end

    assign o_entries = r_mem;
    assign o_valid   = r_valid;
    assign o_head    = r_rd_ptr;
    assign o_count   = r_count;

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: load-use hazard unit for a 5-stage RV32 pipeline with a
// multi-cycle, in-order data memory. Stalls ID on RAW against the load in EX
// or any in-flight load; stalls EX when the outstanding-load FIFO is full.
// Define HAZARD_STATS_EN to add saturating stall/full cycle counters.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int REG_AW      = REG_AW_DEF,
    parameter int DEPTH       = HAZ_DEPTH_DEF,
    parameter int RESP_BYPASS = RESP_BYPASS_ON
)
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [REG_AW-1:0]        i_id_rs1_addr,
    input  logic [REG_AW-1:0]        i_id_rs2_addr,
    input  logic                     i_id_rs1_used,
    input  logic                     i_id_rs2_used,
    input  logic                     i_ex_valid,
    input  logic                     i_ex_mem_read,
    input  logic [REG_AW-1:0]        i_ex_rd_addr,
    input  logic                     i_mem_resp_valid,
    input  logic                     i_flush,
    output logic                     o_stall_id,
    output logic                     o_stall_ex,
    output logic [$clog2(DEPTH):0]   o_pending_cnt,
    output logic                     o_resp_err
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]              o_stall_cycles,
    output logic [31:0]              o_full_cycles
`endif
);

    localparam int CW = cnt_width(DEPTH);
    localparam int PW = $clog2(DEPTH);

    logic [DEPTH-1:0][REG_AW-1:0]   w_entries;
    logic [DEPTH-1:0]               w_valid;
    logic [PW-1:0]                  w_head;
    logic [CW-1:0]                  w_count;
    logic [DEPTH-1:0]               w_head_sel;
    logic [DEPTH-1:0]               w_cmp_mask;
    logic                           w_ex_load;
    logic                           w_ex_hit;
    logic                           w_pend_hit;
    logic                           w_full;
    logic                           w_empty;
    logic                           w_push;
    logic                           w_pop;
    logic                           w_stall_ex;
    logic                           w_stall_id;
    logic                           r_resp_err;

    // x0 is hardwired zero, so it never creates a dependency.
    function automatic logic reg_match(input logic used,
                                       input logic [REG_AW-1:0] rs,
                                       input logic [REG_AW-1:0] rd);
        return used && (rs == rd) && (rd != '0);
    endfunction

    assign w_ex_load  = i_ex_valid & i_ex_mem_read;
    assign w_empty    = (w_count == '0);
    assign w_full     = (w_count == CW'(DEPTH)) & ~i_mem_resp_valid;
    assign w_stall_ex = w_ex_load & w_full & ~i_flush;
    assign w_push     = w_ex_load & ~w_stall_ex & ~i_flush;
    assign w_pop      = i_mem_resp_valid & ~w_empty;

    assign w_ex_hit = w_ex_load &
                      (reg_match(i_id_rs1_used, i_id_rs1_addr, i_ex_rd_addr) |
                       reg_match(i_id_rs2_used, i_id_rs2_addr, i_ex_rd_addr));

    // Select the head slot for exclusion when its response is returning now.
    always_comb begin
        w_head_sel = '0;
        if ((RESP_BYPASS != RESP_BYPASS_OFF) && i_mem_resp_valid) w_head_sel[w_head] = 1'b1;
    end

    assign w_cmp_mask = w_valid & ~w_head_sel;

    // Parallel compare of ID sources against every live in-flight destination.
    always_comb begin
        w_pend_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_cmp_mask[i] &&
                (reg_match(i_id_rs1_used, i_id_rs1_addr, w_entries[i]) ||
                 reg_match(i_id_rs2_used, i_id_rs2_addr, w_entries[i])))
                w_pend_hit = 1'b1;
        end
    end

    assign w_stall_id = (w_ex_hit | w_pend_hit | w_stall_ex) & ~i_flush;

    pending_rd_fifo #(
        .AW    (REG_AW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_push    (w_push),
        .i_push_rd (i_ex_rd_addr),
        .i_pop     (w_pop),
        .o_entries (w_entries),
        .o_valid   (w_valid),
        .o_head    (w_head),
        .o_count   (w_count)
    );

    // A response with nothing outstanding is a protocol error; sticky until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                             r_resp_err <= 1'b0;
        else if (i_mem_resp_valid && w_empty)   r_resp_err <= 1'b1;
    end

`ifdef HAZARD_STATS_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_full_cycles;

    // Saturating cycle counters for ID stalls and FIFO-full EX stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cycles <= '0;
            r_full_cycles  <= '0;
        end else begin
            if (w_stall_id && (r_stall_cycles != '1)) r_stall_cycles <= r_stall_cycles + 32'd1;
            if (w_stall_ex && (r_full_cycles  != '1)) r_full_cycles  <= r_full_cycles  + 32'd1;
        end
    end

    assign o_stall_cycles = r_stall_cycles;
    assign o_full_cycles  = r_full_cycles;
`endif

    assign o_stall_id    = w_stall_id;
    assign o_stall_ex    = w_stall_ex;
    assign o_pending_cnt = w_count;
    assign o_resp_err    = r_resp_err;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed scenarios plus randomized traffic checked
// against a queue-based model of outstanding loads.
module tb_hazard_scoreboard;

    localparam int AW    = 5;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] rs1, rs2, ex_rd;
    logic          u1, u2, ex_valid, ex_mr, resp, flush;
    logic          stall_id, stall_ex, resp_err;
    logic [2:0]    pend;
`ifdef HAZARD_STATS_EN
    logic [31:0]   stall_cycles, full_cycles;
    int            m_stall_cyc, m_full_cyc;
`endif

    int total = 0;
    int bad = 0;
    int q[$];
    bit m_err;

    always #5 clk = ~clk;

    hazard_scoreboard #(.REG_AW(AW), .DEPTH(DEPTH), .RESP_BYPASS(1)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_id_rs1_addr    (rs1),
        .i_id_rs2_addr    (rs2),
        .i_id_rs1_used    (u1),
        .i_id_rs2_used    (u2),
        .i_ex_valid       (ex_valid),
        .i_ex_mem_read    (ex_mr),
        .i_ex_rd_addr     (ex_rd),
        .i_mem_resp_valid (resp),
        .i_flush          (flush),
        .o_stall_id       (stall_id),
        .o_stall_ex       (stall_ex),
        .o_pending_cnt    (pend),
        .o_resp_err       (resp_err)
`ifdef HAZARD_STATS_EN
        ,
        .o_stall_cycles   (stall_cycles),
        .o_full_cycles    (full_cycles)
`endif
    );

    // ---------------- reference model ----------------
    function automatic bit m_match(bit used, int rs, int rd);
        return used && (rs == rd) && (rd != 0);
    endfunction

    function automatic bit m_stall_ex();
        return ex_valid && ex_mr && (q.size() == DEPTH) && !resp && !flush;
    endfunction

    function automatic bit m_stall_id();
        bit hit;
        if (flush) return 1'b0;
        hit = ex_valid && ex_mr && (m_match(u1, int'(rs1), int'(ex_rd)) || m_match(u2, int'(rs2), int'(ex_rd)));
        foreach (q[i]) begin
            if (!(i == 0 && resp) && (m_match(u1, int'(rs1), q[i]) || m_match(u2, int'(rs2), q[i])))
                hit = 1'b1;
        end
        return hit || m_stall_ex();
    endfunction

    task automatic model_reset();
        q.delete();
        m_err = 1'b0;
`ifdef HAZARD_STATS_EN
        m_stall_cyc = 0;
        m_full_cyc = 0;
`endif
    endtask

    task automatic drive(bit ev, bit mr, int rd, int a1, bit x1, int a2, bit x2, bit rv, bit fl);
        ex_valid = ev; ex_mr = mr; ex_rd = AW'(rd);
        rs1 = AW'(a1); u1 = x1; rs2 = AW'(a2); u2 = x2;
        resp = rv; flush = fl;
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Advance one clock, updating the model with the inputs present at the edge.
    task automatic tick();
        bit push, pop;
        @(posedge clk);
        push = ex_valid && ex_mr && !m_stall_ex() && !flush;
        pop  = resp && (q.size() != 0);
        if (resp && q.size() == 0) m_err = 1'b1;
`ifdef HAZARD_STATS_EN
        if (m_stall_id()) m_stall_cyc++;
        if (m_stall_ex()) m_full_cyc++;
`endif
        if (pop)  void'(q.pop_front());
        if (push) q.push_back(int'(ex_rd));
        @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH && q.size() != 0; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
            tick();
        end
        idle();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        #2;
        total++; if (pend !== 3'd0) begin bad++; $display("FAIL reset_pend got=%0d exp=0", pend); end
        total++; if (resp_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", resp_err); end
        total++; if (stall_id !== 1'b0 || stall_ex !== 1'b0) begin bad++; $display("FAIL reset_stalls got=%b%b exp=00", stall_id, stall_ex); end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_load_use();
        drive(1, 1, 5, 5, 1, 0, 0, 0, 0);
        total++; if (stall_id !== 1'b1) begin bad++; $display("FAIL lu_ex_hit got=%b exp=1", stall_id); end
        total++; if (stall_ex !== 1'b0) begin bad++; $display("FAIL lu_stall_ex got=%b exp=0", stall_ex); end
        tick();
        for (int c = 0; c < 2; c++) begin
            drive(0, 0, 0, 5, 1, 0, 0, 0, 0);
            total++; if (stall_id !== 1'b1) begin bad++; $display("FAIL lu_pend_hit c=%0d got=%b exp=1", c, stall_id); end
            total++; if (pend !== 3'd1) begin bad++; $display("FAIL lu_pend_cnt got=%0d exp=1", pend); end
            tick();
        end
        drive(0, 0, 0, 5, 1, 0, 0, 1, 0);
        total++; if (stall_id !== 1'b0) begin bad++; $display("FAIL lu_release got=%b exp=0", stall_id); end
        tick();
        idle();
        total++; if (pend !== 3'd0) begin bad++; $display("FAIL lu_drained got=%0d exp=0", pend); end
    endtask

    task automatic test_x0_unused();
        drive(1, 1, 0, 0, 1, 0, 0, 0, 0);
        total++; if (stall_id !== 1'b0) begin bad++; $display("FAIL x0_stall got=%b exp=0", stall_id); end
        tick();
        idle();
        total++; if (pend !== 3'd1) begin bad++; $display("FAIL x0_pushed got=%0d exp=1", pend); end
        drive(1, 1, 0, 0, 1, 0, 1, 0, 0);
        total++; if (stall_id !== 1'b0) begin bad++; $display("FAIL x0_pending got=%b exp=0", stall_id); end
        drive(1, 1, 7, 0, 0, 7, 0, 0, 0);
        total++; if (stall_id !== 1'b0) begin bad++; $display("FAIL unused_rs2 got=%b exp=0", stall_id); end
        tick();
        idle();
        total++; if (pend !== 3'd2) begin bad++; $display("FAIL unused_pushed got=%0d exp=2", pend); end
        drain();
        total++; if (pend !== 3'd0 || resp_err !== 1'b0) begin bad++; $display("FAIL x0_drain got=%0d/%b exp=0/0", pend, resp_err); end
    endtask

    task automatic test_full();
        for (int i = 1; i <= 4; i++) begin
            drive(1, 1, i, 0, 0, 0, 0, 0, 0);
            total++; if (stall_ex !== 1'b0) begin bad++; $display("FAIL full_fill i=%0d got=%b exp=0", i, stall_ex); end
            tick();
        end
        drive(1, 1, 5, 0, 0, 0, 0, 0, 0);
        total++; if (stall_ex !== 1'b1) begin bad++; $display("FAIL full_stall_ex got=%b exp=1", stall_ex); end
        total++; if (stall_id !== 1'b1) begin bad++; $display("FAIL full_stall_id got=%b exp=1", stall_id); end
        total++; if (pend !== 3'd4) begin bad++; $display("FAIL full_pend got=%0d exp=4", pend); end
        tick();
        drive(1, 1, 5, 0, 0, 0, 0, 0, 0);
        total++; if (pend !== 3'd4 || stall_ex !== 1'b1) begin bad++; $display("FAIL full_hold got=%0d/%b exp=4/1", pend, stall_ex); end
        drive(1, 1, 5, 1, 1, 0, 0, 1, 0);
        total++; if (stall_ex !== 1'b0) begin bad++; $display("FAIL full_resp_ex got=%b exp=0", stall_ex); end
        total++; if (stall_id !== 1'b0) begin bad++; $display("FAIL full_head_bypass got=%b exp=0", stall_id); end
        drive(1, 1, 5, 0, 0, 2, 1, 1, 0);
        total++; if (stall_id !== 1'b1) begin bad++; $display("FAIL full_nonhead got=%b exp=1", stall_id); end
        tick();
        drive(0, 0, 0, 5, 1, 0, 0, 0, 0);
        total++; if (pend !== 3'd4) begin bad++; $display("FAIL full_pushpop got=%0d exp=4", pend); end
        total++; if (stall_id !== 1'b1) begin bad++; $display("FAIL full_new_tail got=%b exp=1", stall_id); end
        drive(0, 0, 0, 1, 1, 0, 0, 0, 0);
        total++; if (stall_id !== 1'b0) begin bad++; $display("FAIL full_old_head got=%b exp=0", stall_id); end
        drain();
    endtask

    task automatic test_flush();
        drive(1, 1, 3, 0, 0, 0, 0, 0, 0);
        tick();
        drive(1, 1, 9, 9, 1, 3, 1, 0, 1);
        total++; if (stall_id !== 1'b0 || stall_ex !== 1'b0) begin bad++; $display("FAIL flush_stalls got=%b%b exp=00", stall_id, stall_ex); end
        tick();
        drive(0, 0, 0, 3, 1, 0, 0, 0, 0);
        total++; if (pend !== 3'd1) begin bad++; $display("FAIL flush_no_push got=%0d exp=1", pend); end
        total++; if (stall_id !== 1'b1) begin bad++; $display("FAIL flush_kept got=%b exp=1", stall_id); end
        drive(0, 0, 0, 9, 1, 0, 0, 0, 0);
        total++; if (stall_id !== 1'b0) begin bad++; $display("FAIL flush_killed got=%b exp=0", stall_id); end
        drain();
    endtask

    task automatic test_wrap();
        bit exp;
        for (int k = 1; k <= 10; k++) begin
            for (int r = 1; r <= 10; r++) begin
                drive(0, 0, 0, r, 1, 0, 0, 0, 0);
                exp = 1'b0;
                foreach (q[i]) if (q[i] == r) exp = 1'b1;
                total++; if (stall_id !== exp) begin bad++; $display("FAIL wrap_probe k=%0d r=%0d got=%b exp=%b", k, r, stall_id, exp); end
            end
            drive(1, 1, k, 0, 0, 0, 0, (k % 2) == 0, 0);
            exp = m_stall_ex();
            total++; if (stall_ex !== exp) begin bad++; $display("FAIL wrap_stall_ex k=%0d got=%b exp=%b", k, stall_ex, exp); end
            tick();
            idle();
            total++; if (pend > 3'd4 || pend !== 3'(q.size())) begin bad++; $display("FAIL wrap_pend k=%0d got=%0d exp=%0d", k, pend, q.size()); end
        end
        drain();
    endtask

    task automatic test_err_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
        tick();
        idle();
        total++; if (resp_err !== 1'b1) begin bad++; $display("FAIL err_set got=%b exp=1", resp_err); end
        total++; if (pend !== 3'd0) begin bad++; $display("FAIL err_pend got=%0d exp=0", pend); end
        drive(1, 1, 6, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        drive(0, 0, 0, 6, 1, 0, 0, 0, 0);
        total++; if (pend !== 3'd2 || resp_err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%0d/%b exp=2/1", pend, resp_err); end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (pend !== 3'd0) begin bad++; $display("FAIL async_rst_pend got=%0d exp=0", pend); end
        total++; if (resp_err !== 1'b0) begin bad++; $display("FAIL async_rst_err got=%b exp=0", resp_err); end
        total++; if (stall_id !== 1'b0) begin bad++; $display("FAIL async_rst_stall got=%b exp=0", stall_id); end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
        tick();
        idle();
        total++; if (resp_err !== 1'b1) begin bad++; $display("FAIL err_after_rst got=%b exp=1", resp_err); end
    endtask

    task automatic test_random();
        bit e_id, e_ex;
        for (int c = 0; c < 400; c++) begin
            drive($urandom_range(3) != 0, $urandom_range(1), $urandom_range(7),
                  $urandom_range(7), $urandom_range(1), $urandom_range(7), $urandom_range(1),
                  $urandom_range(2) == 0, $urandom_range(9) == 0);
            e_id = m_stall_id();
            e_ex = m_stall_ex();
            total++; if (stall_id !== e_id) begin bad++; $display("FAIL rnd_stall_id c=%0d got=%b exp=%b", c, stall_id, e_id); end
            total++; if (stall_ex !== e_ex) begin bad++; $display("FAIL rnd_stall_ex c=%0d got=%b exp=%b", c, stall_ex, e_ex); end
            total++; if (pend !== 3'(q.size())) begin bad++; $display("FAIL rnd_pend c=%0d got=%0d exp=%0d", c, pend, q.size()); end
            total++; if (resp_err !== m_err) begin bad++; $display("FAIL rnd_err c=%0d got=%b exp=%b", c, resp_err, m_err); end
            tick();
        end
        idle();
`ifdef HAZARD_STATS_EN
        total++; if (stall_cycles !== 32'(m_stall_cyc)) begin bad++; $display("FAIL stat_stall got=%0d exp=%0d", stall_cycles, m_stall_cyc); end
        total++; if (full_cycles !== 32'(m_full_cyc)) begin bad++; $display("FAIL stat_full got=%0d exp=%0d", full_cycles, m_full_cyc); end
`endif
    endtask

    initial begin
        model_reset();
        test_reset();
        test_load_use();
        test_x0_unused();
        test_full();
        test_flush();
        test_wrap();
        test_err_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
